// File: rtl/wb_select_stage.sv
// wb_select_stage: write-back result select for the 8-bit CPU.
// Selects ALU / memory / link / immediate, registers a one-cycle
// register-file write, waits for late memory data and counts committed writes.
// Optional feature macro: WB_R0_ZERO_EN (suppress writes to register 0).
module wb_select_stage #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_sel,
    input  logic                  in_we,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]     in_alu,
    input  logic [DATA_W-1:0]     in_link,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  flush,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [CNT_W-1:0]      wr_count
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;
    localparam logic [1:0] SEL_IMM  = 2'b11;

`ifdef WB_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t                  state;
    state_t                  nextState;
    logic                    pendWe;
    logic [REG_ADDR_W-1:0]   pendRd;
    logic                    accept;
    logic                    capture;
    logic                    doWrite;
    logic                    writeEn;
    logic [REG_ADDR_W-1:0]   wrAddr;
    logic [DATA_W-1:0]       wrData;
    logic [DATA_W-1:0]       selData;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready && !flush;

    // Source multiplexer for the request presented this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        selData = in_alu;
        case (in_sel)
            SEL_ALU:  selData = in_alu;
            SEL_MEM:  selData = mem_rdata;
            SEL_LINK: selData = in_link;
            SEL_IMM:  selData = in_imm;
            default:  selData = in_alu;
        endcase
    end

    // Decide this cycle's commit, capture of a late load, and next state.
    always_comb begin
        nextState = state;
        capture   = 1'b0;
        doWrite   = 1'b0;
        wrAddr    = '0;
        wrData    = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_sel == SEL_MEM && !mem_rvalid) begin
                        capture   = 1'b1;
                        nextState = WAIT_MEM;
                    end else begin
                        doWrite = in_we;
                        wrAddr  = in_rd;
                        wrData  = selData;
                    end
                end
            end
            WAIT_MEM: begin
                // A flush wins over a response arriving in the same cycle.
                if (flush) begin
                    nextState = IDLE;
                end else if (mem_rvalid) begin
                    doWrite   = pendWe;
                    wrAddr    = pendRd;
                    wrData    = mem_rdata;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Register 0 may be hard-wired to zero; a suppressed write neither strobes nor counts.
    assign writeEn = doWrite && !(R0_ZERO && (wrAddr == '0));

    // State, pending load fields, registered write port and commit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the pending load fields are reset too, so a load cut off by reset leaves nothing behind.
            state    <= IDLE;
            pendWe   <= 1'b0;
            pendRd   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wr_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= nextState;
            rf_we <= writeEn;
            if (capture) begin
                pendWe <= in_we;
                pendRd <= in_rd;
            end
            if (writeEn) begin
                rf_waddr <= wrAddr;
                rf_wdata <= wrData;
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: directed scenarios plus a
// randomized run against a cycle-level behavioural model. A second instance
// with a 2-bit counter shares the stimulus to exercise counter wrap.
module tb_wb_select_stage;

`ifdef WB_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_we, mem_rvalid, flush;
    logic [1:0] in_sel, in_rd;
    logic [7:0] in_alu, in_link, in_imm, mem_rdata;
    logic       in_ready, rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [15:0] wr_count;
    logic       inReady2, rfWe2;
    logic [1:0] rfWaddr2;
    logic [7:0] rfWdata2;
    logic [1:0] wrCount2;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model state.
    bit         mPend;
    bit         mPendWe;
    logic [1:0] mPendRd;
    bit         mWe;
    logic [1:0] mAddr;
    logic [7:0] mData;
    logic [15:0] mCount;

    always #5 clk = ~clk;

    wb_select_stage #(.DATA_W(8), .REG_ADDR_W(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_we(in_we), .in_rd(in_rd), .in_alu(in_alu),
        .in_link(in_link), .in_imm(in_imm), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .flush(flush), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wr_count(wr_count)
    );

    wb_select_stage #(.DATA_W(8), .REG_ADDR_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inReady2),
        .in_sel(in_sel), .in_we(in_we), .in_rd(in_rd), .in_alu(in_alu),
        .in_link(in_link), .in_imm(in_imm), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .flush(flush), .rf_we(rfWe2),
        .rf_waddr(rfWaddr2), .rf_wdata(rfWdata2), .wr_count(wrCount2)
    );

    task automatic idle_inputs();
        in_valid = 0; in_sel = 0; in_we = 0; in_rd = 0;
        in_alu = 0; in_link = 0; in_imm = 0;
        mem_rvalid = 0; mem_rdata = 0; flush = 0;
    endtask

    task automatic model_reset();
        mPend = 0; mPendWe = 0; mPendRd = 0;
        mWe = 0; mAddr = 0; mData = 0; mCount = 0;
    endtask

    // Advance the model from the current inputs, then clock the DUT and settle.
    task automatic tick();
        logic [7:0] src [4];
        bit         we;
        logic [1:0] wa;
        logic [7:0] wd;
        src[0] = in_alu; src[1] = mem_rdata; src[2] = in_link; src[3] = in_imm;
        we = 0; wa = 0; wd = 0;
        if (!mPend) begin
            if (in_valid && !flush) begin
                if (in_sel == 2'd1 && !mem_rvalid) begin
                    mPend = 1; mPendWe = in_we; mPendRd = in_rd;
                end else begin
                    we = in_we; wa = in_rd; wd = src[in_sel];
                end
            end
        end else if (flush) begin
            mPend = 0;
        end else if (mem_rvalid) begin
            we = mPendWe; wa = mPendRd; wd = mem_rdata; mPend = 0;
        end
        if (R0_ZERO && wa == 2'd0) we = 0;
        mWe = we;
        if (we) begin
            mAddr = wa; mData = wd; mCount = mCount + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        nChecks++; if (rf_we !== 1'b0) begin nFails++; $display("FAIL rst_we: got %0b want 0", rf_we); end
        nChecks++; if (wr_count !== 16'd0) begin nFails++; $display("FAIL rst_count: got %0d want 0", wr_count); end
        #4 reset = 0;
        #1;
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL rst_ready: got %0b want 1", in_ready); end
        // some traffic, then an asynchronous reset mid-stream
        in_valid = 1; in_sel = 2'd0; in_we = 1; in_rd = 2'd1; in_alu = 8'h33;
        tick();
        idle_inputs();
        #2 reset = 1;
        model_reset();
        #1;
        nChecks++; if ({rf_we, rf_waddr, rf_wdata} !== 11'd0) begin nFails++; $display("FAIL rst_mid_out: got we=%0b a=%0d d=%h want 0", rf_we, rf_waddr, rf_wdata); end
        nChecks++; if (wr_count !== 16'd0) begin nFails++; $display("FAIL rst_mid_count: got %0d want 0", wr_count); end
        #2 reset = 0;
    endtask

    task automatic test_alu_write();
        in_valid = 1; in_sel = 2'b00; in_we = 1; in_rd = 2'd2; in_alu = 8'h5A;
        tick();
        idle_inputs();
        nChecks++; if (rf_we !== 1'b1) begin nFails++; $display("FAIL alu_we: got %0b want 1", rf_we); end
        nChecks++; if (rf_waddr !== 2'd2) begin nFails++; $display("FAIL alu_addr: got %0d want 2", rf_waddr); end
        nChecks++; if (rf_wdata !== 8'h5A) begin nFails++; $display("FAIL alu_data: got %h want 5a", rf_wdata); end
        nChecks++; if (wr_count !== 16'd1) begin nFails++; $display("FAIL alu_count: got %0d want 1", wr_count); end
        nChecks++; if (wrCount2 !== 2'd1) begin nFails++; $display("FAIL wrap_1: got %0d want 1", wrCount2); end
        tick();
        nChecks++; if (rf_we !== 1'b0) begin nFails++; $display("FAIL alu_pulse: got %0b want 0", rf_we); end
        nChecks++; if (rf_wdata !== 8'h5A) begin nFails++; $display("FAIL alu_hold: got %h want 5a", rf_wdata); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1; in_we = 1; in_sel = 2'b10; in_link = 8'h11; in_rd = 2'd1;
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL b2b_ready0: got %0b want 1", in_ready); end
        tick();
        nChecks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 2'd1, 8'h11}) begin nFails++; $display("FAIL b2b_first: got we=%0b a=%0d d=%h want 1/1/11", rf_we, rf_waddr, rf_wdata); end
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL b2b_ready1: got %0b want 1", in_ready); end
        nChecks++; if (wrCount2 !== 2'd2) begin nFails++; $display("FAIL wrap_2: got %0d want 2", wrCount2); end
        in_sel = 2'b11; in_imm = 8'hF0; in_rd = 2'd3;
        tick();
        idle_inputs();
        nChecks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 2'd3, 8'hF0}) begin nFails++; $display("FAIL b2b_second: got we=%0b a=%0d d=%h want 1/3/f0", rf_we, rf_waddr, rf_wdata); end
        nChecks++; if (wrCount2 !== 2'd3) begin nFails++; $display("FAIL wrap_3: got %0d want 3", wrCount2); end
        tick();
        nChecks++; if (rf_we !== 1'b0) begin nFails++; $display("FAIL b2b_end: got %0b want 0", rf_we); end
    endtask

    task automatic test_mem_wait();
        in_valid = 1; in_we = 1; in_sel = 2'b01; in_rd = 2'd1; mem_rvalid = 0;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL memw_ready[%0d]: got %0b want 0", i, in_ready); end
            nChecks++; if (rf_we !== 1'b0) begin nFails++; $display("FAIL memw_we[%0d]: got %0b want 0", i, rf_we); end
            if (i == 2) begin mem_rvalid = 1; mem_rdata = 8'hC3; end
            tick();
        end
        idle_inputs();
        nChecks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 2'd1, 8'hC3}) begin nFails++; $display("FAIL memw_write: got we=%0b a=%0d d=%h want 1/1/c3", rf_we, rf_waddr, rf_wdata); end
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL memw_ready_back: got %0b want 1", in_ready); end
        nChecks++; if (wrCount2 !== 2'd0) begin nFails++; $display("FAIL wrap_0: got %0d want 0", wrCount2); end
        // load that hits in the same cycle: no wait
        in_valid = 1; in_we = 1; in_sel = 2'b01; in_rd = 2'd2; mem_rvalid = 1; mem_rdata = 8'h3C;
        tick();
        idle_inputs();
        nChecks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 2'd2, 8'h3C}) begin nFails++; $display("FAIL memhit_write: got we=%0b a=%0d d=%h want 1/2/3c", rf_we, rf_waddr, rf_wdata); end
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL memhit_ready: got %0b want 1", in_ready); end
        nChecks++; if (wr_count !== 16'd5) begin nFails++; $display("FAIL memhit_count: got %0d want 5", wr_count); end
        nChecks++; if (wrCount2 !== 2'd1) begin nFails++; $display("FAIL wrap_1b: got %0d want 1", wrCount2); end
    endtask

    task automatic test_flush();
        // pending load killed by flush in the same cycle as its response
        in_valid = 1; in_we = 1; in_sel = 2'b01; in_rd = 2'd3; mem_rvalid = 0;
        tick();
        idle_inputs();
        flush = 1; mem_rvalid = 1; mem_rdata = 8'h77;
        tick();
        idle_inputs();
        nChecks++; if (rf_we !== 1'b0) begin nFails++; $display("FAIL flush_we: got %0b want 0", rf_we); end
        nChecks++; if (wr_count !== 16'd5) begin nFails++; $display("FAIL flush_count: got %0d want 5", wr_count); end
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL flush_idle: got %0b want 1", in_ready); end
        // flush in IDLE blocks acceptance
        in_valid = 1; in_we = 1; in_sel = 2'b00; in_rd = 2'd1; in_alu = 8'hEE; flush = 1;
        tick();
        idle_inputs();
        nChecks++; if (rf_we !== 1'b0) begin nFails++; $display("FAIL flush_block: got %0b want 0", rf_we); end
        // load with we=0 consumes the response without writing
        in_valid = 1; in_we = 0; in_sel = 2'b01; in_rd = 2'd2;
        tick();
        idle_inputs();
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL nowe_wait: got %0b want 0", in_ready); end
        mem_rvalid = 1; mem_rdata = 8'h12;
        tick();
        idle_inputs();
        nChecks++; if (rf_we !== 1'b0 || in_ready !== 1'b1) begin nFails++; $display("FAIL nowe_done: got we=%0b ready=%0b want 0/1", rf_we, in_ready); end
        nChecks++; if (wr_count !== 16'd5) begin nFails++; $display("FAIL nowe_count: got %0d want 5", wr_count); end
    endtask

    task automatic test_reset_wait();
        in_valid = 1; in_we = 1; in_sel = 2'b01; in_rd = 2'd1; mem_rvalid = 0;
        tick();
        idle_inputs();
        #2 reset = 1;
        model_reset();
        #1;
        nChecks++; if ({rf_we, rf_waddr, rf_wdata} !== 11'd0) begin nFails++; $display("FAIL rstw_out: got we=%0b a=%0d d=%h want 0", rf_we, rf_waddr, rf_wdata); end
        nChecks++; if (wr_count !== 16'd0) begin nFails++; $display("FAIL rstw_count: got %0d want 0", wr_count); end
        #2 reset = 0;
        #1;
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL rstw_ready: got %0b want 1", in_ready); end
        mem_rvalid = 1; mem_rdata = 8'hAA;
        tick();
        idle_inputs();
        nChecks++; if (rf_we !== 1'b0 || wr_count !== 16'd0) begin nFails++; $display("FAIL rstw_stale: got we=%0b cnt=%0d want 0/0", rf_we, wr_count); end
    endtask

    task automatic test_r0();
        in_valid = 1; in_we = 1; in_sel = 2'b00; in_rd = 2'd0; in_alu = 8'h99;
        tick();
        idle_inputs();
        nChecks++; if (rf_we !== !R0_ZERO) begin nFails++; $display("FAIL r0_we: got %0b want %0b", rf_we, !R0_ZERO); end
        nChecks++; if (wr_count !== (R0_ZERO ? 16'd0 : 16'd1)) begin nFails++; $display("FAIL r0_count: got %0d want %0d", wr_count, R0_ZERO ? 0 : 1); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 9) < 6);
            in_sel     = 2'($urandom_range(0, 3));
            in_we      = ($urandom_range(0, 9) < 8);
            in_rd      = 2'($urandom_range(0, 3));
            in_alu     = 8'($urandom);
            in_link    = 8'($urandom);
            in_imm     = 8'($urandom);
            mem_rvalid = ($urandom_range(0, 9) < 4);
            mem_rdata  = 8'($urandom);
            flush      = ($urandom_range(0, 9) == 0);
            nChecks++; if (in_ready !== !mPend) begin nFails++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, in_ready, !mPend); end
            tick();
            nChecks++; if (rf_we !== mWe) begin nFails++; $display("FAIL rnd_we[%0d]: got %0b want %0b", i, rf_we, mWe); end
            nChecks++; if (rf_waddr !== mAddr) begin nFails++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", i, rf_waddr, mAddr); end
            nChecks++; if (rf_wdata !== mData) begin nFails++; $display("FAIL rnd_data[%0d]: got %h want %h", i, rf_wdata, mData); end
            nChecks++; if (wr_count !== mCount) begin nFails++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, wr_count, mCount); end
            nChecks++; if (wrCount2 !== mCount[1:0]) begin nFails++; $display("FAIL rnd_count2[%0d]: got %0d want %0d", i, wrCount2, mCount[1:0]); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_back_to_back();
        test_mem_wait();
        test_flush();
        test_reset_wait();
        test_r0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
